execute_mdu: RTL and testbench

Parametrised execute stage for the minuteCore pipeline with an integrated iterative multiply/divide unit (RV32M/RV64M). It sits between decode and memory access and replaces the single-cycle, stall/flush-only execute stage with a valid/ready-handshaked stage that can hold an instruction for multiple cycles. Base ALU, branch, jump, load/store address, and LUI/AUIPC ops complete in one cycle. M-extension ops take `XLEN/MDU_BPC` iteration cycles. Branch/jump redirects are produced registered, alongside the result.

---
 rtl/execute_mdu.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_execute_mdu.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/execute_mdu.sv
// minuteCore execute stage: single-cycle ALU/branch/address ops plus an iterative
// multiply/divide unit that retires MDU_BPC bits per cycle behind a valid/ready handshake.
module execute_mdu #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MDU_BPC = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc_in,
    input  logic [4:0]      opcode_in,
    input  logic [2:0]      funct3_in,
    input  logic            variant,
    input  logic            mext,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [XLEN-1:0] offset,
    input  logic [4:0]      rd_addr_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] addr,
    output logic [4:0]      rd_addr_out,
    output logic [4:0]      opcode_out,
    output logic [2:0]      funct3_out,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_addr,
    output logic            busy
);
    localparam logic [4:0] OpLoad     = 5'b00000;
    localparam logic [4:0] OpArithImm = 5'b00100;
    localparam logic [4:0] OpAuipc    = 5'b00101;
    localparam logic [4:0] OpStore    = 5'b01000;
    localparam logic [4:0] OpArith    = 5'b01100;
    localparam logic [4:0] OpLui      = 5'b01101;
    localparam logic [4:0] OpBranch   = 5'b11000;
    localparam logic [4:0] OpJalr     = 5'b11001;
    localparam logic [4:0] OpJal      = 5'b11011;
    localparam logic [4:0] OpSystem   = 5'b11100;

    localparam int unsigned Iters = XLEN / MDU_BPC;
    localparam int unsigned CntW  = $clog2(Iters);
    localparam int unsigned ShW   = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     iter_cnt_q, iter_cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic                is_div_q, is_div_d;
    logic                neg_a_q, neg_a_d;
    logic                neg_res_q, neg_res_d;
    logic                div_zero_q, div_zero_d;
    logic                out_valid_q, out_valid_d;
    logic                redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]     redirect_addr_q, redirect_addr_d;
    logic [4:0]          rd_addr_q, rd_addr_d;
    logic [4:0]          opcode_q, opcode_d;
    logic [2:0]          funct3_q, funct3_d;

    logic                accept, is_m;
    logic [ShW-1:0]      shamt;
    logic [XLEN-1:0]     alu_res, exec_res, jalr_sum, redir_tgt;
    logic                br_taken, redir_taken;
    logic                sign_a, sign_b, neg_a, neg_b;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic [2*XLEN-1:0]   step_acc, mul_full;
    logic [XLEN:0]       rem_sh, diff, sum;
    logic [XLEN-1:0]     quo_fix, rem_fix, mdu_res;

    assign in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    assign accept   = in_valid && in_ready;
    assign is_m     = (opcode_in == OpArith) && mext;
    assign shamt    = op2[ShW-1:0];
    assign jalr_sum = op1 + op2;

    always_comb begin
        alu_res = '0;
        unique case (funct3_in)
            3'b000: alu_res = (opcode_in == OpArith && variant) ? op1 - op2 : op1 + op2;
            3'b001: alu_res = op1 << shamt;
            3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
            3'b011: alu_res = {{(XLEN-1){1'b0}}, op1 < op2};
            3'b100: alu_res = op1 ^ op2;
            3'b101: alu_res = variant ? XLEN'($signed(op1) >>> shamt) : op1 >> shamt;
            3'b110: alu_res = op1 | op2;
            3'b111: alu_res = op1 & op2;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3_in)
            3'b000: br_taken = (op1 == op2);
            3'b001: br_taken = (op1 != op2);
            3'b100: br_taken = $signed(op1) < $signed(op2);
            3'b101: br_taken = $signed(op1) >= $signed(op2);
            3'b110: br_taken = op1 < op2;
            3'b111: br_taken = op1 >= op2;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        exec_res    = '0;
        redir_taken = 1'b0;
        redir_tgt   = pc_in + offset;
        case (opcode_in)
            OpArith, OpArithImm: exec_res = alu_res;
            OpLui:    exec_res = op2;
            OpAuipc:  exec_res = pc_in + op2;
            OpLoad:   exec_res = '0;
            OpStore:  exec_res = op2;
            OpSystem: exec_res = op1;
            OpJal: begin
                exec_res    = pc_in + XLEN'(4);
                redir_taken = 1'b1;
                redir_tgt   = pc_in + op2;
            end
            OpJalr: begin
                exec_res    = pc_in + XLEN'(4);
                redir_taken = 1'b1;
                redir_tgt   = jalr_sum & ~XLEN'(1);
            end
            OpBranch: redir_taken = br_taken;
            default:  exec_res = '0;
        endcase
    end

    // Operand signedness: MUL/MULH/MULHSU sign rs1, MUL/MULH sign rs2; DIV/REM sign both.
    always_comb begin
        if (funct3_in[2]) begin
            sign_a = !funct3_in[0];
            sign_b = !funct3_in[0];
        end else begin
            sign_a = (funct3_in[1:0] != 2'b11);
            sign_b = !funct3_in[1];
        end
        neg_a = sign_a && op1[XLEN-1];
        neg_b = sign_b && op2[XLEN-1];
        mag_a = neg_a ? -op1 : op1;
        mag_b = neg_b ? -op2 : op2;
    end

    // acc holds {product hi, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    always_comb begin
        step_acc = acc_q;
        rem_sh   = '0;
        diff     = '0;
        sum      = '0;
        for (int i = 0; i < MDU_BPC; i++) begin
            if (is_div_q) begin
                rem_sh = {step_acc[2*XLEN-1:XLEN], step_acc[XLEN-1]};
                diff   = rem_sh - {1'b0, opnd_q};
                if (!diff[XLEN]) begin
                    step_acc = {diff[XLEN-1:0], step_acc[XLEN-2:0], 1'b1};
                end else begin
                    step_acc = {rem_sh[XLEN-1:0], step_acc[XLEN-2:0], 1'b0};
                end
            end else begin
                sum      = {1'b0, step_acc[2*XLEN-1:XLEN]} +
                           (step_acc[0] ? {1'b0, opnd_q} : '0);
                step_acc = {sum, step_acc[XLEN-1:1]};
            end
        end
    end

    always_comb begin
        mul_full = neg_res_q ? -step_acc : step_acc;
        quo_fix  = div_zero_q ? '1 :
                   (neg_res_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0]);
        rem_fix  = neg_a_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
        if (is_div_q) begin
            mdu_res = funct3_q[1] ? rem_fix : quo_fix;
        end else begin
            mdu_res = (funct3_q[1:0] == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d          = state_q;
        iter_cnt_d       = iter_cnt_q;
        acc_d            = acc_q;
        opnd_d           = opnd_q;
        is_div_d         = is_div_q;
        neg_a_d          = neg_a_q;
        neg_res_d        = neg_res_q;
        div_zero_d       = div_zero_q;
        out_valid_d      = out_valid_q;
        redirect_valid_d = redirect_valid_q;
        result_d         = result_q;
        addr_d           = addr_q;
        redirect_addr_d  = redirect_addr_q;
        rd_addr_d        = rd_addr_q;
        opcode_d         = opcode_q;
        funct3_d         = funct3_q;

        case (state_q)
            StBusy: begin
                acc_d      = step_acc;
                iter_cnt_d = iter_cnt_q - CntW'(1);
                if (iter_cnt_q == '0) begin
                    result_d    = mdu_res;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d      = 1'b0;
                    redirect_valid_d = 1'b0;
                    state_d          = StIdle;
                end
            end
            default: ;
        endcase

        if (accept) begin
            rd_addr_d = rd_addr_in;
            opcode_d  = opcode_in;
            funct3_d  = funct3_in;
            if (is_m) begin
                is_div_d         = funct3_in[2];
                neg_a_d          = neg_a;
                neg_res_d        = neg_a ^ neg_b;
                div_zero_d       = (op2 == '0);
                opnd_d           = funct3_in[2] ? mag_b : mag_a;
                acc_d            = {{XLEN{1'b0}}, (funct3_in[2] ? mag_a : mag_b)};
                iter_cnt_d       = CntW'(Iters - 1);
                out_valid_d      = 1'b0;
                redirect_valid_d = 1'b0;
                state_d          = StBusy;
            end else begin
                result_d         = exec_res;
                addr_d           = op1 + ((opcode_in == OpStore) ? offset : op2);
                redirect_valid_d = redir_taken;
                redirect_addr_d  = redir_tgt;
                out_valid_d      = 1'b1;
                state_d          = StDone;
            end
        end

        if (flush) begin
            out_valid_d      = 1'b0;
            redirect_valid_d = 1'b0;
            state_d          = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= StIdle;
            iter_cnt_q       <= '0;
            acc_q            <= '0;
            opnd_q           <= '0;
            is_div_q         <= 1'b0;
            neg_a_q          <= 1'b0;
            neg_res_q        <= 1'b0;
            div_zero_q       <= 1'b0;
            out_valid_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
            result_q         <= '0;
            addr_q           <= '0;
            redirect_addr_q  <= '0;
            rd_addr_q        <= '0;
            opcode_q         <= '0;
            funct3_q         <= '0;
        end else begin
            state_q          <= state_d;
            iter_cnt_q       <= iter_cnt_d;
            acc_q            <= acc_d;
            opnd_q           <= opnd_d;
            is_div_q         <= is_div_d;
            neg_a_q          <= neg_a_d;
            neg_res_q        <= neg_res_d;
            div_zero_q       <= div_zero_d;
            out_valid_q      <= out_valid_d;
            redirect_valid_q <= redirect_valid_d;
            result_q         <= result_d;
            addr_q           <= addr_d;
            redirect_addr_q  <= redirect_addr_d;
            rd_addr_q        <= rd_addr_d;
            opcode_q         <= opcode_d;
            funct3_q         <= funct3_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign redirect_valid = redirect_valid_q;
    assign result         = result_q;
    assign addr           = addr_q;
    assign redirect_addr  = redirect_addr_q;
    assign rd_addr_out    = rd_addr_q;
    assign opcode_out     = opcode_q;
    assign funct3_out     = funct3_q;
    assign busy           = (state_q == StBusy);

endmodule

// File: tb/tb_execute_mdu.sv
// Directed bench for execute_mdu: one instance with MDU_BPC=1, one with MDU_BPC=4.
module tb_execute_mdu;
    localparam logic [4:0] OpArith = 5'b01100;
    localparam logic [4:0] OpStore = 5'b01000;
    localparam logic [4:0] OpBranch = 5'b11000;
    localparam logic [4:0] OpJalr = 5'b11001;
    localparam logic [4:0] OpJal = 5'b11011;
    localparam logic [4:0] OpLui = 5'b01101;

    logic        clk = 1'b0;
    logic        reset, flush, flush2, in_valid, in_valid2, out_ready;
    logic [31:0] pc_in, op1, op2, offset;
    logic [4:0]  opcode_in, rd_addr_in;
    logic [2:0]  funct3_in;
    logic        variant, mext;

    logic        in_ready, out_valid, redirect_valid, busy;
    logic [31:0] result, addr, redirect_addr;
    logic [4:0]  rd_addr_out, opcode_out;
    logic [2:0]  funct3_out;

    logic        in_ready2, out_valid2, redirect_valid2, busy2;
    logic [31:0] result2, addr2, redirect_addr2;
    logic [4:0]  rd_addr_out2, opcode_out2;
    logic [2:0]  funct3_out2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    execute_mdu #(.XLEN(32), .MDU_BPC(1)) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .opcode_in(opcode_in), .funct3_in(funct3_in), .variant(variant),
        .mext(mext), .op1(op1), .op2(op2), .offset(offset), .rd_addr_in(rd_addr_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .addr(addr),
        .rd_addr_out(rd_addr_out), .opcode_out(opcode_out), .funct3_out(funct3_out),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .busy(busy)
    );

    execute_mdu #(.XLEN(32), .MDU_BPC(4)) u_dut4 (
        .clk(clk), .reset(reset), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
        .pc_in(pc_in), .opcode_in(opcode_in), .funct3_in(funct3_in), .variant(variant),
        .mext(mext), .op1(op1), .op2(op2), .offset(offset), .rd_addr_in(rd_addr_in),
        .out_valid(out_valid2), .out_ready(out_ready), .result(result2), .addr(addr2),
        .rd_addr_out(rd_addr_out2), .opcode_out(opcode_out2), .funct3_out(funct3_out2),
        .redirect_valid(redirect_valid2), .redirect_addr(redirect_addr2), .busy(busy2)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one instruction and holds it for exactly one rising edge.
    task automatic issue(input int sel, input logic [4:0] opc, input logic [2:0] f3,
                         input logic var_i, input logic m, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] off,
                         input logic [4:0] rd);
        opcode_in = opc; funct3_in = f3; variant = var_i; mext = m;
        pc_in = pc; op1 = a; op2 = b; offset = off; rd_addr_in = rd;
        if (sel == 0) in_valid = 1'b1; else in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_valid2 = 1'b0;
    endtask

    // Counts edges after accept until out_valid, and samples with busy high along the way.
    task automatic wait_done(input int sel, output int lat, output int busy_cnt);
        lat = 0; busy_cnt = 0;
        while (((sel == 0) ? !out_valid : !out_valid2) && lat < 200) begin
            if ((sel == 0) ? busy : busy2) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat, bc, ov_cnt;
        reset = 1'b1; flush = 1'b0; flush2 = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
        out_ready = 1'b1; pc_in = '0; op1 = '0; op2 = '0; offset = '0; opcode_in = '0;
        funct3_in = '0; variant = 1'b0; mext = 1'b0; rd_addr_in = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_redirect", redirect_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_result", result, 0);
        check_eq("rst_rd", rd_addr_out, 0);

        // Back-to-back single-cycle ops
        issue(0, OpArith, 3'b000, 1'b0, 1'b0, 32'h0, 32'd5, 32'hFFFF_FFFD, 32'h0, 5'd7);
        check_eq("add_result", result, 32'd2);
        check_eq("add_valid", out_valid, 1);
        check_eq("add_rd", rd_addr_out, 5'd7);
        check_eq("add_opcode", opcode_out, OpArith);
        check_eq("b2b_in_ready", in_ready, 1);
        issue(0, OpArith, 3'b010, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0, 5'd8);
        check_eq("slt_result", result, 32'd1);
        check_eq("slt_valid", out_valid, 1);
        check_eq("slt_funct3", funct3_out, 3'b010);
        @(posedge clk); #1;
        check_eq("consumed_valid", out_valid, 0);

        issue(0, OpArith, 3'b101, 1'b1, 1'b0, 32'h0, 32'h8000_0000, 32'd4, 32'h0, 5'd1);
        check_eq("sra", result, 32'hF800_0000);
        issue(0, OpArith, 3'b000, 1'b1, 1'b0, 32'h0, 32'd3, 32'd5, 32'h0, 5'd1);
        check_eq("sub", result, 32'hFFFF_FFFE);
        issue(0, OpLui, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1234_5000, 32'h0, 5'd1);
        check_eq("lui", result, 32'h1234_5000);
        issue(0, OpStore, 3'b010, 1'b0, 1'b0, 32'h0, 32'h1000, 32'hDEAD, 32'h8, 5'd0);
        check_eq("store_addr", addr, 32'h1008);
        check_eq("store_data", result, 32'hDEAD);

        // Multiply latency and values
        issue(0, OpArith, 3'b000, 1'b0, 1'b1, 32'h0, 32'd7, 32'hFFFF_FFFD, 32'h0, 5'd2);
        wait_done(0, lat, bc);
        check_eq("mul_latency", lat, 32);
        check_eq("mul_busy_cycles", bc, 32);
        check_eq("mul_result", result, 32'hFFFF_FFEB);
        issue(0, OpArith, 3'b011, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 5'd2);
        check_eq("mulhu_in_ready", in_ready, 0);
        wait_done(0, lat, bc);
        check_eq("mulhu_result", result, 32'hFFFF_FFFE);

        // Division incl. special cases
        issue(0, OpArith, 3'b100, 1'b0, 1'b1, 32'h0, 32'd100, 32'd0, 32'h0, 5'd3);
        wait_done(0, lat, bc);
        check_eq("div0_latency", lat, 32);
        check_eq("div0_quot", result, 32'hFFFF_FFFF);
        issue(0, OpArith, 3'b110, 1'b0, 1'b1, 32'h0, 32'd100, 32'd0, 32'h0, 5'd3);
        wait_done(0, lat, bc);
        check_eq("rem0", result, 32'd100);
        issue(0, OpArith, 3'b100, 1'b0, 1'b1, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 5'd3);
        wait_done(0, lat, bc);
        check_eq("divovf_latency", lat, 32);
        check_eq("divovf_quot", result, 32'h8000_0000);
        issue(0, OpArith, 3'b110, 1'b0, 1'b1, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 5'd3);
        wait_done(0, lat, bc);
        check_eq("removf", result, 32'd0);
        issue(0, OpArith, 3'b100, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFF9, 32'd2, 32'h0, 5'd3);
        wait_done(0, lat, bc);
        check_eq("div_neg", result, 32'hFFFF_FFFD);
        issue(0, OpArith, 3'b110, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFF9, 32'd2, 32'h0, 5'd3);
        wait_done(0, lat, bc);
        check_eq("rem_neg", result, 32'hFFFF_FFFF);
        @(posedge clk); #1;

        // Backpressure
        out_ready = 1'b0;
        issue(0, OpArith, 3'b000, 1'b0, 1'b0, 32'h0, 32'd10, 32'd20, 32'h0, 5'd4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("bp_result", result, 32'd30);
            check_eq("bp_valid", out_valid, 1);
            check_eq("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", in_ready, 1);
        issue(0, OpArith, 3'b100, 1'b0, 1'b0, 32'h0, 32'hF0, 32'h0F, 32'h0, 5'd5);
        check_eq("bp_next_result", result, 32'hFF);
        check_eq("bp_next_valid", out_valid, 1);

        // Redirects
        issue(0, OpBranch, 3'b001, 1'b0, 1'b0, 32'h100, 32'd3, 32'd4, 32'h20, 5'd0);
        check_eq("bne_taken", redirect_valid, 1);
        check_eq("bne_target", redirect_addr, 32'h120);
        issue(0, OpBranch, 3'b000, 1'b0, 1'b0, 32'h100, 32'd3, 32'd4, 32'h20, 5'd0);
        check_eq("beq_not_taken", redirect_valid, 0);
        issue(0, OpBranch, 3'b010, 1'b0, 1'b0, 32'h100, 32'd3, 32'd3, 32'h20, 5'd0);
        check_eq("br_undef", redirect_valid, 0);
        issue(0, OpJalr, 3'b000, 1'b0, 1'b0, 32'h400, 32'h203, 32'h0, 32'h0, 5'd1);
        check_eq("jalr_taken", redirect_valid, 1);
        check_eq("jalr_target", redirect_addr, 32'h202);
        check_eq("jalr_link", result, 32'h404);
        issue(0, OpJal, 3'b000, 1'b0, 1'b0, 32'h1000, 32'h0, 32'h10, 32'h0, 5'd1);
        check_eq("jal_target", redirect_addr, 32'h1010);
        check_eq("jal_link", result, 32'h1004);
        @(posedge clk); #1;

        // Flush mid-divide
        issue(0, OpArith, 3'b100, 1'b0, 1'b1, 32'h0, 32'd1000, 32'd7, 32'h0, 5'd6);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_eq("flush_busy", busy, 0);
        check_eq("flush_valid", out_valid, 0);
        check_eq("flush_in_ready", in_ready, 1);
        ov_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) ov_cnt++;
        end
        check_eq("flush_no_valid", ov_cnt, 0);

        // MDU_BPC=4 instance
        issue(1, OpArith, 3'b101, 1'b0, 1'b1, 32'h0, 32'd1000, 32'd7, 32'h0, 5'd6);
        repeat (3) @(posedge clk);
        #1;
        flush2 = 1'b1;
        @(posedge clk); #1;
        flush2 = 1'b0;
        check_eq("bpc4_flush_busy", busy2, 0);
        check_eq("bpc4_flush_ready", in_ready2, 1);
        issue(1, OpArith, 3'b101, 1'b0, 1'b1, 32'h0, 32'd1000, 32'd7, 32'h0, 5'd6);
        wait_done(1, lat, bc);
        check_eq("bpc4_divu_latency", lat, 8);
        check_eq("bpc4_divu", result2, 32'd142);
        issue(1, OpArith, 3'b111, 1'b0, 1'b1, 32'h0, 32'd1000, 32'd7, 32'h0, 5'd6);
        wait_done(1, lat, bc);
        check_eq("bpc4_remu", result2, 32'd6);
        issue(1, OpArith, 3'b000, 1'b0, 1'b1, 32'h0, 32'd7, 32'hFFFF_FFFD, 32'h0, 5'd6);
        wait_done(1, lat, bc);
        check_eq("bpc4_mul", result2, 32'hFFFF_FFEB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
